// File: rtl/uart_tx_fifo_if.sv
// Bundle of the producer write port and the transmitter launch handshake
// of uart_tx_fifo. The FIFO takes the slave view; the producer/transmitter
// side (or a testbench standing in for both) takes the master view.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);

  // Producer side: one byte per cycle while wr_dv is high.
  logic              wr_dv;
  logic [7:0]        wr_byte;

  // Occupancy and drop reporting back to the producer.
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  // Launch handshake with the UART transmitter.
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active;
  logic              tx_done;

  // Block-level activity flag.
  logic              busy;

  modport master (
    output wr_dv,
    output wr_byte,
    output tx_active,
    output tx_done,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  tx_dv,
    input  tx_byte,
    input  busy
  );

  modport slave (
    input  wr_dv,
    input  wr_byte,
    input  tx_active,
    input  tx_done,
    output full,
    output empty,
    output count,
    output overflow,
    output tx_dv,
    output tx_byte,
    output busy
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller in front of a UART transmitter.
// Producers write at clock rate; bytes are handed to the transmitter one at
// a time through its data-valid / active / done handshake, strictly in write
// order. Writes into a full FIFO are dropped and flagged with a one-cycle
// overflow pulse. Reset is synchronous and active-low.
//
// DEPTH must be a power of two (>= 2) and ADDR_W must equal log2(DEPTH);
// both pointers rely on natural ADDR_W-bit wrap to stay modulo DEPTH.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  uart_tx_fifo_if.slave     bus
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  // Launch controller states. S_WAIT_ACTIVE waits for the transmitter to
  // pick up the byte; S_WAIT_DONE waits for it to finish shifting it out.
  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACTIVE = 2'd1,
    S_WAIT_DONE   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;

  logic              overflow_q;
  logic              tx_dv_q;
  logic [7:0]        tx_byte_q;

  logic              full;
  logic              empty;
  logic              accept;
  logic              drop;
  logic              pop;

  // ---------------------------------------------------------------------
  // Status flags come from the registered count only, so nothing on the
  // write port reaches full/empty/count combinationally.
  // ---------------------------------------------------------------------
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // A write is taken only against the registered full flag. A pop in the
  // same cycle frees a slot for the next cycle, not this one.
  assign accept = bus.wr_dv & ~full;
  assign drop   = bus.wr_dv &  full;

  // Next-state and pop decision for the launch controller.
  // NOTE: every output of an always_comb block gets a default before the
  // case statement; a path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // The transmitter has no reset; waiting for Active to be low keeps
        // us from launching into a byte it is still sending.
        if (!empty && !bus.tx_active) begin
          pop     = 1'b1;
          state_d = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_ACTIVE: begin
        // A stray Done here is ignored; only Active moves us on.
        if (bus.tx_active) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Launch controller state register.
  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values; blocking = here would make results depend on
  // statement and process ordering.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately left out of reset. Cleared pointers and
  // count already make every entry unreachable, and an unreset array maps
  // onto RAM instead of a wide bank of resettable flops.
  always_ff @(posedge i_Clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= bus.wr_byte;
    end
  end

  // Write pointer: advances on every accepted byte, wraps modulo DEPTH.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
    end else if (accept) begin
      wr_ptr_q <= wr_ptr_q + PTR_ONE;
    end
  end

  // Read pointer: advances on every launch, wraps modulo DEPTH.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      rd_ptr_q <= '0;
    end else if (pop) begin
      rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy: +1 on accept, -1 on pop, unchanged when both or neither.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      count_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Launch outputs: DV is high for exactly the cycle after a pop; the byte
  // is captured on the pop and held until the next launch.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      tx_dv_q <= pop;
      if (pop) begin
        tx_byte_q <= mem[rd_ptr_q];
      end
    end
  end

  // One-cycle overflow pulse for each write dropped while full.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_dv    = tx_dv_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.busy     = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. A behavioural transmitter raises Active
// right after each launch and pulses Done (dropping Active) TX_CYCLES later.
// Every byte the bench expects to be sent is queued when it is written and
// compared when the DUT launches it.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int TX_CYCLES = 40;  // 10 bit-times of 4 clocks

  logic clk;
  logic rst_n;

  // Transmitter model state, plus direct overrides used by directed steps.
  logic model_active;
  logic model_done;
  logic force_busy;
  logic stray_done;
  int   model_timer;
  logic prev_dv;

  int   n_tests;
  int   n_fail;
  int   launches;

  logic [7:0] exp_q [$];

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.tx_active = force_busy | model_active;
  assign bus.tx_done   = model_done | stray_done;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive one write for one edge; returns at the following negedge with
  // wr_dv still high so consecutive calls form a burst.
  task automatic wr(input logic [7:0] b, input bit exp_accept);
    bus.wr_dv   = 1'b1;
    bus.wr_byte = b;
    if (exp_accept) exp_q.push_back(b);
    tick();
  endtask

  task automatic stop_wr();
    bus.wr_dv   = 1'b0;
    bus.wr_byte = 8'h00;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n = 0;
    while (!(bus.empty && !bus.busy && !bus.tx_active && !model_done) && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < max_cycles), 1);
  endtask

  // Transmitter model and launch scoreboard, evaluated just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_done) model_done = 1'b0;
      if (bus.tx_dv) begin
        launches++;
        check("dv_single_cycle", 32'(prev_dv), 0);
        check("launch_while_active", 32'(bus.tx_active), 0);
        check("launch_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_byte_order", bus.tx_byte, exp_q.pop_front());
        model_active = 1'b1;
        model_timer  = TX_CYCLES;
      end else if (model_timer > 0) begin
        model_timer--;
        if (model_timer == 0) begin
          model_active = 1'b0;
          model_done   = 1'b1;
        end
      end
      prev_dv = bus.tx_dv;
    end
  end

  initial begin
    int l0;
    int peak;

    n_tests      = 0;
    n_fail       = 0;
    launches     = 0;
    model_active = 1'b0;
    model_done   = 1'b0;
    model_timer  = 0;
    prev_dv      = 1'b0;
    force_busy   = 1'b0;
    stray_done   = 1'b0;
    rst_n        = 1'b0;
    bus.wr_dv    = 1'b0;
    bus.wr_byte  = 8'h00;

    // ---- Reset values ----
    repeat (3) tick();
    check("rst_empty",    32'(bus.empty),    1);
    check("rst_full",     32'(bus.full),     0);
    check("rst_busy",     32'(bus.busy),     0);
    check("rst_count",    32'(bus.count),    0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_tx_dv",    32'(bus.tx_dv),    0);
    check("rst_tx_byte",  32'(bus.tx_byte),  0);
    rst_n = 1'b1;
    tick();

    // ---- Single byte: launch after edge k+1 ----
    l0 = launches;
    wr(8'h55, 1'b1);
    stop_wr();
    check("single_count_after_k", 32'(bus.count), 1);
    check("single_dv_after_k",    32'(bus.tx_dv), 0);
    check("single_empty_after_k", 32'(bus.empty), 0);
    tick();
    check("single_dv_after_k1",   32'(bus.tx_dv),   1);
    check("single_byte",          32'(bus.tx_byte), 32'h55);
    check("single_empty_pop",     32'(bus.empty),   1);
    check("single_busy_in_xfer",  32'(bus.busy),    1);
    wait_idle(TX_CYCLES + 20, "single");
    check("single_busy_after_done", 32'(bus.busy), 0);
    check("single_launches", launches - l0, 1);

    // ---- Burst 0x01..0x05 ----
    l0   = launches;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      wr(8'(i), 1'b1);
      if (int'(bus.count) > peak) peak = int'(bus.count);
    end
    stop_wr();
    check("burst_peak_4_or_5", 32'(peak >= 4 && peak <= 5), 1);
    wait_idle(5 * (TX_CYCLES + 10) + 20, "burst");
    check("burst_launches", launches - l0, 5);
    check("burst_queue_drained", exp_q.size(), 0);

    // ---- Fill with transmitter held busy, overflow twice ----
    l0 = launches;
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h10 + i), 1'b1);
    check("fill_full",  32'(bus.full),     1);
    check("fill_count", 32'(bus.count),    DEPTH);
    check("fill_no_ov", 32'(bus.overflow), 0);
    wr(8'h20, 1'b0);
    check("ov1_pulse", 32'(bus.overflow), 1);
    check("ov1_count", 32'(bus.count),    DEPTH);
    wr(8'h21, 1'b0);
    check("ov2_pulse", 32'(bus.overflow), 1);

    // ---- Write while full in the same cycle as a pop ----
    force_busy = 1'b0;
    wr(8'h22, 1'b0);
    stop_wr();
    check("popfull_overflow", 32'(bus.overflow), 1);
    check("popfull_count",    32'(bus.count),    DEPTH - 1);
    check("popfull_dv",       32'(bus.tx_dv),    1);
    check("popfull_full_off", 32'(bus.full),     0);
    tick();
    check("popfull_ov_end",   32'(bus.overflow), 0);
    check("popfull_count_hold", 32'(bus.count),  DEPTH - 1);
    wait_idle(DEPTH * (TX_CYCLES + 10) + 50, "fill");
    check("fill_launches", launches - l0, DEPTH);
    check("fill_queue_drained", exp_q.size(), 0);

    // ---- Reset mid-transfer with bytes queued ----
    l0 = launches;
    wr(8'hA0, 1'b1);
    stop_wr();
    tick();
    check("midrst_first_launch", launches - l0, 1);
    wr(8'hA1, 1'b1);
    wr(8'hA2, 1'b1);
    wr(8'hA3, 1'b1);
    stop_wr();
    tick();
    check("midrst_queued", 32'(bus.count), 3);
    check("midrst_busy",   32'(bus.busy),  1);
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_count",   32'(bus.count),   0);
    check("midrst_empty",   32'(bus.empty),   1);
    check("midrst_busy0",   32'(bus.busy),    0);
    check("midrst_tx_dv",   32'(bus.tx_dv),   0);
    check("midrst_tx_byte", 32'(bus.tx_byte), 0);
    rst_n = 1'b1;
    l0 = launches;
    begin
      int n = 0;
      while (bus.tx_active && n < TX_CYCLES + 20) begin
        tick();
        n++;
      end
      check("midrst_active_timeout", 32'(n < TX_CYCLES + 20), 1);
    end
    tick();
    check("midrst_no_launch", launches - l0, 0);
    wr(8'h77, 1'b1);
    stop_wr();
    wait_idle(TX_CYCLES + 20, "midrst_new");
    check("midrst_new_launch", launches - l0, 1);

    // ---- Stray Done while idle and empty ----
    l0 = launches;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("stray_busy",  32'(bus.busy),  0);
    check("stray_empty", 32'(bus.empty), 1);
    check("stray_dv",    32'(bus.tx_dv), 0);
    repeat (3) tick();
    check("stray_no_launch", launches - l0, 0);
    check("stray_busy_later", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
